// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined integer ALU with valid/ready on both sides.
//
// Stage 1 registers the accepted operands, opcode and tag. Stage 2 computes
// the result and flags and registers them into the output slot. Throughput is
// one operation per cycle. At most two operations are buffered (stage 1 plus
// the output slot), and results leave strictly in order.
//
// Opcodes (x = don't care):
//   x000 ADD    x100 SUB    x001 AND    x101 OR     x010 XOR
//   x110 LUI    0011 SLL    0111 SRL    1111 SRA    1011 MUL / SLL
// Shift opcodes shift b by a[$clog2(WIDTH)-1:0].
//
// Optional feature macro: ALU_MUL_EN
//   Defined   : 1011 is an unsigned iterative multiply (one bit per cycle,
//               IDLE -> RUN -> DONE). Only the low WIDTH bits are kept.
//   Undefined : 1011 behaves as SLL. No sequencer is built.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   clrn       asynchronous active-low reset
//   in_valid   operation offered          in_ready   operation accepted this cycle
//   a, b       operands                   aluc       opcode
//   tag_in     tag returned with result   tag_out    tag of presented result
//   out_valid  result valid               out_ready  consumer takes result
//   r          result                     z          r == 0
//   c          carry (ADD) / no-borrow (SUB), else 0
//   v          signed overflow (ADD/SUB), else 0
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    input  logic [TAGW-1:0]  tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic [TAGW-1:0]  tag_out
);

    localparam int SHW = $clog2(WIDTH);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [3:0]       s1_op_r;
    logic [TAGW-1:0]  s1_tag_r;

    logic             adv_s;
    logic             idle_s;
    logic [SHW-1:0]   sh_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_r_s;
    logic             alu_c_s;
    logic             alu_v_s;

    // The output slot frees up when it is empty or being drained this cycle.
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s && idle_s;
    assign sh_s     = s1_a_r[SHW-1:0];

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    mul_state_t       mul_state_r;
    mul_state_t       mul_state_nxt_s;
    logic [WIDTH-1:0] mul_mc_r;
    logic [WIDTH-1:0] mul_mp_r;
    logic [WIDTH-1:0] mul_acc_r;
    logic [WIDTH-1:0] mul_acc_nxt_s;
    logic [SHW-1:0]   mul_cnt_r;
    logic [TAGW-1:0]  mul_tag_r;
    logic             mul_start_s;
    logic             mul_last_s;

    assign idle_s        = (mul_state_r == MUL_IDLE);
    // A multiply leaves stage 1 exactly when a normal op would move to stage 2.
    assign mul_start_s   = adv_s && idle_s && s1_valid_r && (s1_op_r == OP_MUL);
    assign mul_last_s    = (mul_state_r == MUL_RUN) && (mul_cnt_r == {SHW{1'b0}});
    assign mul_acc_nxt_s = mul_mp_r[0] ? (mul_acc_r + mul_mc_r) : mul_acc_r;

    // Multiplier sequencer next-state logic.
    always_comb begin
        mul_state_nxt_s = mul_state_r;
        case (mul_state_r)
            MUL_IDLE: begin
                if (mul_start_s) mul_state_nxt_s = MUL_RUN;
                else             mul_state_nxt_s = MUL_IDLE;
            end
            MUL_RUN: begin
                if (mul_cnt_r == {SHW{1'b0}}) mul_state_nxt_s = MUL_DONE;
                else                          mul_state_nxt_s = MUL_RUN;
            end
            // DONE: the product sits in the output slot until it is taken.
            MUL_DONE: begin
                if (adv_s) mul_state_nxt_s = MUL_IDLE;
                else       mul_state_nxt_s = MUL_DONE;
            end
            default: mul_state_nxt_s = MUL_IDLE;
        endcase
    end

    // Multiplier sequencer state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) mul_state_r <= MUL_IDLE;
        else       mul_state_r <= mul_state_nxt_s;
    end

    // Shift-add datapath: one multiplier bit per RUN cycle, counter WIDTH-1 down to 0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mul_mc_r  <= {WIDTH{1'b0}};
            mul_mp_r  <= {WIDTH{1'b0}};
            mul_acc_r <= {WIDTH{1'b0}};
            mul_cnt_r <= {SHW{1'b0}};
            mul_tag_r <= {TAGW{1'b0}};
        end else if (mul_start_s) begin
            mul_mc_r  <= s1_a_r;
            mul_mp_r  <= s1_b_r;
            mul_acc_r <= {WIDTH{1'b0}};
            mul_cnt_r <= SHW'(WIDTH - 1);
            mul_tag_r <= s1_tag_r;
        end else if (mul_state_r == MUL_RUN) begin
            mul_acc_r <= mul_acc_nxt_s;
            mul_mc_r  <= mul_mc_r << 1;
            mul_mp_r  <= mul_mp_r >> 1;
            mul_cnt_r <= mul_cnt_r - {{(SHW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign idle_s = 1'b1;
`endif

    // Stage-1 operand/opcode/tag register; frozen while the output slot is stalled.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 4'b0000;
            s1_tag_r   <= {TAGW{1'b0}};
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r   <= a;
                s1_b_r   <= b;
                s1_op_r  <= aluc;
                s1_tag_r <= tag_in;
            end
        end
    end

    // Stage-2 combinational ALU on the stage-1 contents.
    always_comb begin
        // SUB reuses the adder as a + ~b + 1, so c reads as "no borrow".
        b_eff_s = s1_op_r[2] ? ~s1_b_r : s1_b_r;
        sum_s   = {1'b0, s1_a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, s1_op_r[2]};
        alu_r_s = {WIDTH{1'b0}};
        alu_c_s = 1'b0;
        alu_v_s = 1'b0;
        case (s1_op_r[1:0])
            2'b00: begin
                alu_r_s = sum_s[WIDTH-1:0];
                alu_c_s = sum_s[WIDTH];
                alu_v_s = (s1_a_r[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                          (sum_s[WIDTH-1] != s1_a_r[WIDTH-1]);
            end
            2'b01: begin
                if (s1_op_r[2]) alu_r_s = s1_a_r | s1_b_r;
                else            alu_r_s = s1_a_r & s1_b_r;
            end
            2'b10: begin
                if (s1_op_r[2]) alu_r_s = {s1_b_r[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                else            alu_r_s = s1_a_r ^ s1_b_r;
            end
            2'b11: begin
                if (!s1_op_r[2])     alu_r_s = s1_b_r << sh_s;
                else if (s1_op_r[3]) alu_r_s = $unsigned($signed(s1_b_r) >>> sh_s);
                else                 alu_r_s = s1_b_r >> sh_s;
            end
            default: alu_r_s = {WIDTH{1'b0}};
        endcase
    end

    // Output slot: loads on advance, holds while stalled.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            r         <= {WIDTH{1'b0}};
            z         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            tag_out   <= {TAGW{1'b0}};
`ifdef ALU_MUL_EN
        end else if (mul_last_s) begin
            // The final partial product is folded in on the way to the output.
            out_valid <= 1'b1;
            r         <= mul_acc_nxt_s;
            z         <= (mul_acc_nxt_s == {WIDTH{1'b0}});
            c         <= 1'b0;
            v         <= 1'b0;
            tag_out   <= mul_tag_r;
        end else if (!idle_s) begin
            // Stage 1 is frozen while multiplying, so a drained slot stays empty.
            if (adv_s) out_valid <= 1'b0;
        end else if (mul_start_s) begin
            out_valid <= 1'b0;
`endif
        end else if (adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                r       <= alu_r_s;
                z       <= (alu_r_s == {WIDTH{1'b0}});
                c       <= alu_c_s;
                v       <= alu_v_s;
                tag_out <= s1_tag_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- scoreboard bench for alu_pipe (WIDTH=32, TAGW=4).
// Directed vectors push hand-computed results into a queue on acceptance;
// a negedge monitor pops and compares whenever a result is transferred, and
// checks that a stalled result stays stable.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W  = 32;
    localparam int T  = 4;
    localparam int EW = W + 3 + T;

    logic         clk;
    logic         clrn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   aluc;
    logic [T-1:0] tag_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
    logic [T-1:0] tag_out;

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;

    logic [EW-1:0] exp_q[$];
    logic          held = 1'b0;
    logic [EW-1:0] held_val;
    logic [EW-1:0] got_val;
    logic [EW-1:0] want_val;

    alu_pipe #(.WIDTH(W), .TAGW(T)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .aluc(aluc), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .z(z), .c(c), .v(v), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Offer one op, wait (bounded) for acceptance, then record its expected result.
    task automatic send(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [T-1:0] tg, input logic [W-1:0] er,
                        input logic ec, input logic ev);
        bit done;
        done     = 1'b0;
        aluc     = op;
        a        = aa;
        b        = bb;
        tag_in   = tg;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (done) begin
            exp_q.push_back({er, (er == {W{1'b0}}), ec, ev, tg});
            accepted++;
        end else begin
            check("accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare every transferred result, and check stall stability.
    always @(negedge clk) begin
        got_val = {r, z, c, v, tag_out};
        if (!clrn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!out_valid || got_val !== held_val) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b %h, expected valid=1 %h",
                             out_valid, got_val, held_val);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got r=%h tag=%h, expected no output", r, tag_out);
                end else begin
                    want_val = exp_q.pop_front();
                    if (got_val !== want_val) begin
                        errors++;
                        $display("FAIL result: got r=%h z=%b c=%b v=%b tag=%h, expected r=%h z=%b c=%b v=%b tag=%h",
                                 r, z, c, v, tag_out, want_val[EW-1 -: W], want_val[T+2],
                                 want_val[T+1], want_val[T], want_val[T-1:0]);
                    end
                end
            end
            held     = out_valid && !out_ready;
            held_val = got_val;
        end
    end

    int base;
    int lat;
    bit busy_ok;
    bit ov_seen;

    initial begin
        clrn      = 1'b0;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        aluc      = 4'h0;
        tag_in    = 4'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'({r, z, c, v, tag_out}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // ADD with latency measured in cycles from the accepting cycle.
        send(4'b0000, 32'd1, 32'd2, 4'd3, 32'h3, 1'b0, 1'b0);
        lat = 1;
        while (lat < 60) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("add_latency", 64'(lat), 64'd2);
        drain();

        // Arithmetic flags, logic ops, LUI and shifts, streamed back-to-back.
        send(4'b0100, 32'hffffffff, 32'hffffffff, 4'd4,  32'h00000000, 1'b1, 1'b0);
        send(4'b0000, 32'h7fffffff, 32'h00000001, 4'd5,  32'h80000000, 1'b0, 1'b1);
        send(4'b0000, 32'hffffffff, 32'h00000001, 4'd6,  32'h00000000, 1'b1, 1'b0);
        send(4'b1000, 32'h00000005, 32'h00000006, 4'd7,  32'h0000000b, 1'b0, 1'b0);
        send(4'b0100, 32'h00000005, 32'h00000003, 4'd8,  32'h00000002, 1'b1, 1'b0);
        send(4'b0100, 32'h00000003, 32'h00000005, 4'd9,  32'hfffffffe, 1'b0, 1'b0);
        send(4'b0100, 32'h80000000, 32'h00000001, 4'd10, 32'h7fffffff, 1'b1, 1'b1);
        send(4'b0001, 32'hcccccccc, 32'haaaaaaaa, 4'd11, 32'h88888888, 1'b0, 1'b0);
        send(4'b0101, 32'hcccccccc, 32'haaaaaaaa, 4'd12, 32'heeeeeeee, 1'b0, 1'b0);
        send(4'b0010, 32'h33333333, 32'hff005555, 4'd13, 32'hcc336666, 1'b0, 1'b0);
        send(4'b0110, 32'h12345678, 32'hff005555, 4'd14, 32'h55550000, 1'b0, 1'b0);
        send(4'b0011, 32'h0000000f, 32'hffffffff, 4'd15, 32'hffff8000, 1'b0, 1'b0);
        send(4'b0111, 32'h0000000f, 32'hffffffff, 4'd0,  32'h0001ffff, 1'b0, 1'b0);
        send(4'b1111, 32'h00000010, 32'h7f000000, 4'd1,  32'h00007f00, 1'b0, 1'b0);
        send(4'b1111, 32'h00000010, 32'hffffff00, 4'd2,  32'hffffffff, 1'b0, 1'b0);
        send(4'b0011, 32'h00000021, 32'h00000001, 4'd3,  32'h00000002, 1'b0, 1'b0);
        drain();

        // Backpressure: four ops while the consumer stalls for five cycles.
        out_ready = 1'b0;
        base      = accepted;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(4'b0000, W'(i), 32'd10, T'(i), W'(10 + i), 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stall_accept_count", 64'(accepted - base), 64'd2);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef ALU_MUL_EN
        // MUL latency and input blocking while the multiplier is busy.
        send(4'b1011, 32'd3, 32'd5, 4'h9, 32'h0000000f, 1'b0, 1'b0);
        lat     = 1;
        busy_ok = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            if (out_valid) break;
            if (lat >= 2 && in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd34);
        check("mul_in_ready_low", 64'(busy_ok), 64'd1);
        drain();

        // Wrapping product, then an ADD that must wait behind it; zero product.
        send(4'b1011, 32'hffffffff, 32'hffffffff, 4'h1, 32'h00000001, 1'b0, 1'b0);
        send(4'b0000, 32'd1, 32'd1, 4'h2, 32'h00000002, 1'b0, 1'b0);
        send(4'b1011, 32'd0, 32'h1234, 4'h6, 32'h00000000, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a multiply discards it.
        send(4'b1011, 32'd7, 32'd9, 4'h5, 32'h0000003f, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        clrn = 1'b0;
        exp_q.delete();
        #2;
        check("reset_mid_mul_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        clrn    = 1'b1;
        ov_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        check("reset_discard", 64'(ov_seen), 64'd0);
        check("ready_after_reset", 64'(in_ready), 64'd1);
`else
        // Without the multiplier, 1011 is a left shift.
        send(4'b1011, 32'd4, 32'd1, 4'h7, 32'h00000010, 1'b0, 1'b0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
